dpram_r1w1_bwe: RTL and testbench

Single-clock true dual-port RAM and the parametrised successor of the fixed 16-bit r1w1 dual-port RAM. Adds configurable data width, per-byte write enables, a selectable read-during-write mode, an optional output register, deterministic cross-port collision resolution with a collision flag, and a post-reset clear sequencer. It sits between CPU or DMA masters and local buffers in the SoC fabric and is also exercised through the MyHDL cosimulation benches.

---
 rtl/dpram_pkg.sv | 32 +++
 rtl/dpram_clear_seq.sv | 48 ++++
 rtl/dpram_r1w1_bwe.sv | 140 ++++++++++++++
 tb/tb_dpram_r1w1_bwe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the byte-enabled dual-port RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    // Widest word the merge helper handles; callers extend/truncate to DATA_W.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    typedef logic [MAX_DATA_W-1:0] word_t;
    typedef logic [MAX_BYTES-1:0]  lane_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

    function automatic word_t byte_merge(input word_t old_word, input word_t new_word,
                                         input lane_t be);
        word_t res;
        res = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sweep: writes zero to every address, then hands over to RUN.
// Latency: sweep lasts 2**ADDR_W cycles after reset release.
// Backpressure: none; ports are ignored while init_busy is high.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign init_busy = (state == ST_CLEAR);
    assign clr_we    = (state == ST_CLEAR);
    assign clr_addr  = cnt;

endmodule

// File: rtl/dpram_r1w1_bwe.sv
// Single-clock true dual-port RAM with byte enables, RDW modes and collision flag.
// Latency: read 1 cycle (OREG=0) or 2 cycles (OREG=1); coll 1 cycle.
// Backpressure: none; accesses are dropped while init_busy is high.
module dpram_r1w1_bwe
    import dpram_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int RDW_MODE       = 0,
    parameter int OREG           = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_busy,
    input  logic                a_ce,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_write,
    output logic [DATA_W-1:0]   a_read,
    input  logic                b_ce,
    input  logic [DATA_W/8-1:0] b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_write,
    output logic [DATA_W-1:0]   b_read,
    output logic                coll
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dpram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic             a_en, b_en;
    logic [BYTES-1:0] a_wen, b_wen;
    logic [DATA_W-1:0] a_old, b_old;

    assign a_en  = a_ce & ~init_busy;
    assign b_en  = b_ce & ~init_busy;
    assign a_wen = a_en ? a_we : '0;
    assign b_wen = b_en ? b_we : '0;
    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];

    // Port B lanes are written after port A so B wins overlapping lanes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_wen[i]) mem[a_addr][8*i +: 8] <= a_write[8*i +: 8];
            end
            for (int i = 0; i < BYTES; i++) begin
                if (b_wen[i]) mem[b_addr][8*i +: 8] <= b_write[8*i +: 8];
            end
        end
    end

    // Reads always see the pre-write array, so the other port's write is invisible.
    logic              a_upd, b_upd;
    logic [DATA_W-1:0] a_val, b_val;

    always_comb begin
        a_upd = a_en;
        a_val = a_old;
        if (a_wen != '0) begin
            if (RDW_MODE == RDW_WRITE_FIRST)
                a_val = DATA_W'(byte_merge(word_t'(a_old), word_t'(a_write), lane_t'(a_wen)));
            else if (RDW_MODE == RDW_NO_CHANGE)
                a_upd = 1'b0;
        end
    end

    always_comb begin
        b_upd = b_en;
        b_val = b_old;
        if (b_wen != '0) begin
            if (RDW_MODE == RDW_WRITE_FIRST)
                b_val = DATA_W'(byte_merge(word_t'(b_old), word_t'(b_write), lane_t'(b_wen)));
            else if (RDW_MODE == RDW_NO_CHANGE)
                b_upd = 1'b0;
        end
    end

    logic [DATA_W-1:0] a_q1, b_q1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q1 <= '0;
            b_q1 <= '0;
            coll <= 1'b0;
        end else begin
            if (a_upd) a_q1 <= a_val;
            if (b_upd) b_q1 <= b_val;
            coll <= a_en & b_en & (a_addr == b_addr) & ((a_wen != '0) | (b_wen != '0));
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic              a_ce_q, b_ce_q;
            logic [DATA_W-1:0] a_q2, b_q2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_ce_q <= 1'b0;
                    b_ce_q <= 1'b0;
                    a_q2   <= '0;
                    b_q2   <= '0;
                end else begin
                    a_ce_q <= a_en;
                    b_ce_q <= b_en;
                    if (a_ce_q) a_q2 <= a_q1;
                    if (b_ce_q) b_q2 <= b_q1;
                end
            end

            assign a_read = a_q2;
            assign b_read = b_q2;
        end else begin : g_direct
            assign a_read = a_q1;
            assign b_read = b_q1;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_r1w1_bwe.sv
// Bench for dpram_r1w1_bwe: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE,
// READ_FIRST+OREG) share one stimulus stream and one behavioural model.
module tb_dpram_r1w1_bwe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_ce = 1'b0, b_ce = 1'b0;
    logic [3:0]    a_we = '0, b_we = '0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_write = '0, b_write = '0;

    logic [DW-1:0] a_rd [4];
    logic [DW-1:0] b_rd [4];
    logic          busy_o [4];
    logic          coll_o [4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dpram_r1w1_bwe #(
            .ADDR_W         (AW),
            .DATA_W         (DW),
            .RDW_MODE       ((g == 3) ? 0 : g),
            .OREG           ((g == 3) ? 1 : 0),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .init_busy (busy_o[g]),
            .a_ce      (a_ce),
            .a_we      (a_we),
            .a_addr    (a_addr),
            .a_write   (a_write),
            .a_read    (a_rd[g]),
            .b_ce      (b_ce),
            .b_we      (b_we),
            .b_addr    (b_addr),
            .b_write   (b_write),
            .b_read    (b_rd[g]),
            .coll      (coll_o[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [DEPTH];
    logic [31:0] st_a [3] = '{default: '0};
    logic [31:0] st_b [3] = '{default: '0};
    logic [31:0] q2_a = '0, q2_b = '0;
    bit          ce_pa = 0, ce_pb = 0;
    bit          m_busy = 1, m_coll = 0;
    int          m_cnt = 0;

    function automatic logic [31:0] lane_mix(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) if (be[i]) mask |= 32'hFF << (8 * i);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [31:0] oa, ob;
        if (reset) begin
            for (int m = 0; m < 3; m++) begin st_a[m] = '0; st_b[m] = '0; end
            q2_a = '0; q2_b = '0; ce_pa = 0; ce_pb = 0;
            m_busy = 1; m_cnt = 0; m_coll = 0;
        end else if (m_busy) begin
            mem_m[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_busy = 0;
            m_coll = 0; ce_pa = 0; ce_pb = 0;
        end else begin
            oa = mem_m[a_addr];
            ob = mem_m[b_addr];
            m_coll = a_ce && b_ce && (a_addr == b_addr) && (a_we != 0 || b_we != 0);
            if (ce_pa) q2_a = st_a[0];
            if (ce_pb) q2_b = st_b[0];
            ce_pa = a_ce; ce_pb = b_ce;
            for (int m = 0; m < 3; m++) begin
                if (a_ce) begin
                    if (a_we == 0 || m == 0) st_a[m] = oa;
                    else if (m == 1)         st_a[m] = lane_mix(oa, a_write, a_we);
                end
                if (b_ce) begin
                    if (b_we == 0 || m == 0) st_b[m] = ob;
                    else if (m == 1)         st_b[m] = lane_mix(ob, b_write, b_we);
                end
            end
            if (a_ce) mem_m[a_addr] = lane_mix(mem_m[a_addr], a_write, a_we);
            if (b_ce) mem_m[b_addr] = lane_mix(mem_m[b_addr], b_write, b_we);
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            check($sformatf("a_read_%0d", g), a_rd[g], (g == 3) ? q2_a : st_a[g]);
            check($sformatf("b_read_%0d", g), b_rd[g], (g == 3) ? q2_b : st_b[g]);
            check($sformatf("init_busy_%0d", g), 32'(busy_o[g]), 32'(m_busy));
            check($sformatf("coll_%0d", g), 32'(coll_o[g]), 32'(m_coll));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_ce = 0; a_we = '0; b_ce = 0; b_we = '0;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] we);
        a_ce = 1; a_addr = addr; a_write = d; a_we = we;
    endtask

    task automatic rd_b(input logic [3:0] addr);
        b_ce = 1; b_addr = addr; b_we = '0;
    endtask

    task automatic measure_sweep(input string name);
        int n;
        n = 0;
        while (busy_o[0] && n < 40) begin
            n++;
            cyc();
        end
        check(name, 32'(n), 32'd16);
    endtask

    initial begin
        logic [31:0] prev;
        #1 reset = 1;
        cyc(); cyc();
        reset = 0;
        measure_sweep("sweep_len_first");

        // byte enables
        wr_a(4'd3, 32'hAABBCCDD, 4'b1111); cyc();
        wr_a(4'd3, 32'h11223344, 4'b0101); cyc();
        idle(); rd_b(4'd3); cyc();
        check("byte_en_b_read", b_rd[0], 32'hAA22CC44);

        // read-during-write modes
        idle(); wr_a(4'd5, 32'h1, 4'b1111); cyc();
        idle(); a_ce = 1; a_addr = 4'd3; cyc();
        prev = a_rd[2];
        check("nc_prev_value", prev, 32'hAA22CC44);
        wr_a(4'd5, 32'h2, 4'b1111); cyc();
        check("rdw_read_first", a_rd[0], 32'h1);
        check("rdw_write_first", a_rd[1], 32'h2);
        check("rdw_no_change", a_rd[2], 32'hAA22CC44);

        // dual write collision
        idle();
        wr_a(4'd7, 32'hFFFFFFFF, 4'b1111);
        b_ce = 1; b_addr = 4'd7; b_write = 32'h0; b_we = 4'b0011;
        cyc();
        check("dual_write_coll", 32'(coll_o[0]), 32'd1);
        idle(); cyc();
        check("dual_write_coll_drop", 32'(coll_o[0]), 32'd0);
        rd_b(4'd7); cyc();
        check("dual_write_data", b_rd[0], 32'hFFFF0000);

        // cross-port read while write
        idle(); wr_a(4'd9, 32'h5, 4'b1111); cyc();
        wr_a(4'd9, 32'h6, 4'b1111); rd_b(4'd9); cyc();
        check("xport_old_rf", b_rd[0], 32'h5);
        check("xport_old_wf", b_rd[1], 32'h5);
        check("xport_coll", 32'(coll_o[1]), 32'd1);
        idle(); rd_b(4'd9); cyc();
        check("xport_new", b_rd[0], 32'h6);

        // fill array with nonzero data, then reset twice (second one mid-sweep)
        idle();
        for (int i = 0; i < 8; i++) begin
            wr_a(4'(2 * i), 32'h01010101 * (2 * i + 1), 4'b1111);
            b_ce = 1; b_addr = 4'(2 * i + 1); b_write = 32'hF0F0F0F0 ^ i; b_we = 4'b1111;
            cyc();
        end
        idle();
        reset = 1; cyc(); reset = 0;
        repeat (8) cyc();
        check("busy_mid_sweep", 32'(busy_o[3]), 32'd1);
        reset = 1; cyc(); reset = 0;
        measure_sweep("sweep_len_restart");
        for (int i = 0; i < DEPTH; i++) begin
            a_ce = 1; a_addr = 4'(i); b_ce = 1; b_addr = 4'(DEPTH - 1 - i);
            cyc();
        end
        check("cleared_a15", a_rd[0], 32'h0);
        check("cleared_b0", b_rd[0], 32'h0);

        // output register latency
        idle(); wr_a(4'd2, 32'hCAFEF00D, 4'b1111); cyc();
        idle(); a_ce = 1; a_addr = 4'd2; cyc();
        check("oreg_not_yet", a_rd[3], 32'h0);
        check("noreg_one_cycle", a_rd[0], 32'hCAFEF00D);
        idle(); cyc();
        check("oreg_two_cycles", a_rd[3], 32'hCAFEF00D);
        a_addr = 4'd9; cyc();
        check("oreg_hold", a_rd[3], 32'hCAFEF00D);

        cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
